stopwatch_core: RTL

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 45 ++++
 rtl/tick_divider.sv | 29 ++
 rtl/stopwatch_core.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, encodings and packed-BCD helpers for the stopwatch core.
package stopwatch_pkg;

    localparam int unsigned BcdW = 4;

    localparam logic SelMin = 1'b0;
    localparam logic SelSec = 1'b1;

    typedef logic [2*BcdW-1:0] bcd2_t;

    typedef enum logic [1:0] {
        ModePause  = 2'd0,
        ModeRun    = 2'd1,
        ModeAdjust = 2'd2
    } mode_e;

    localparam bcd2_t SecMax = 8'h59;

    function automatic bcd2_t to_bcd2(input int unsigned v);
        return {BcdW'(v / 10), BcdW'(v % 10)};
    endfunction

    // Increment with wrap to 00 once max_v is reached.
    function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max_v);
        if (v == max_v) begin
            return '0;
        end
        if (v[BcdW-1:0] == 4'd9) begin
            return {v[2*BcdW-1:BcdW] + 4'd1, 4'd0};
        end
        return {v[2*BcdW-1:BcdW], v[BcdW-1:0] + 4'd1};
    endfunction

    // Decrement with wrap from 00 to max_v.
    function automatic bcd2_t bcd_dec(input bcd2_t v, input bcd2_t max_v);
        if (v == '0) begin
            return max_v;
        end
        if (v[BcdW-1:0] == 4'd0) begin
            return {v[2*BcdW-1:BcdW] - 4'd1, 4'd9};
        end
        return {v[2*BcdW-1:BcdW], v[BcdW-1:0] - 4'd1};
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: one-cycle tick_o every DIV clocks, cleared by rst_i.
module tick_divider #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: BCD mm:ss up/down counter with adjust, lap freeze and blink.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned ADJ_HZ   = 2,
    parameter int unsigned BLINK_HZ = 4,
    parameter int unsigned MIN_MAX  = 59
) (
    input  logic       clk_i,
    input  logic       btnr_i,
    input  logic       pause_pulse_i,
    input  logic       lap_pulse_i,
    input  logic       adj_i,
    input  logic       sel_i,
    input  logic       dir_i,
    output logic [7:0] disp_min_o,
    output logic [7:0] disp_sec_o,
    output logic       running_o,
    output logic       lap_active_o,
    output logic       blink_o,
    output logic       done_o
);

    localparam bcd2_t MinMax = to_bcd2(MIN_MAX);

    logic tick_1hz, tick_adj, tick_blink;

    tick_divider #(.DIV(CLK_HZ)) u_div_1hz (
        .clk_i (clk_i),
        .rst_i (btnr_i),
        .tick_o(tick_1hz)
    );

    tick_divider #(.DIV(CLK_HZ / ADJ_HZ)) u_div_adj (
        .clk_i (clk_i),
        .rst_i (btnr_i),
        .tick_o(tick_adj)
    );

    tick_divider #(.DIV(CLK_HZ / (2 * BLINK_HZ))) u_div_blink (
        .clk_i (clk_i),
        .rst_i (btnr_i),
        .tick_o(tick_blink)
    );

    bcd2_t min_q, min_d, sec_q, sec_d;
    bcd2_t lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;
    bcd2_t disp_min_q, disp_min_d, disp_sec_q, disp_sec_d;
    logic  running_q, running_d, lap_active_q, lap_active_d;
    logic  blink_q, blink_d, done_q, done_d;
    mode_e mode;

    always_comb begin
        if (adj_i) begin
            mode = ModeAdjust;
        end else if (running_q) begin
            mode = ModeRun;
        end else begin
            mode = ModePause;
        end
    end

    // running_q is left untouched in adjust, so leaving adjust restores it implicitly.
    always_comb begin
        min_d        = min_q;
        sec_d        = sec_q;
        running_d    = running_q;
        blink_d      = 1'b1;
        done_d       = 1'b0;
        lap_active_d = lap_active_q ^ lap_pulse_i;
        lap_min_d    = lap_min_q;
        lap_sec_d    = lap_sec_q;
        if (lap_pulse_i && !lap_active_q) begin
            lap_min_d = min_q;
            lap_sec_d = sec_q;
        end
        unique case (mode)
            ModeAdjust: begin
                blink_d = tick_blink ? ~blink_q : blink_q;
                if (tick_adj) begin
                    unique case (sel_i)
                        SelMin: min_d = bcd_inc(min_q, MinMax);
                        SelSec: sec_d = bcd_inc(sec_q, SecMax);
                        default: ;
                    endcase
                end
            end
            ModeRun: begin
                running_d = ~pause_pulse_i;
                if (tick_1hz) begin
                    if (!dir_i) begin
                        sec_d = bcd_inc(sec_q, SecMax);
                        if (sec_q == SecMax) begin
                            min_d = bcd_inc(min_q, MinMax);
                        end
                    end else if (min_q != '0 || sec_q != '0) begin
                        sec_d = bcd_dec(sec_q, SecMax);
                        if (sec_q == '0) begin
                            min_d = bcd_dec(min_q, MinMax);
                        end
                        if (min_q == '0 && sec_q == 8'h01) begin
                            done_d    = 1'b1;
                            running_d = 1'b0;
                        end
                    end
                end
            end
            ModePause: running_d = pause_pulse_i;
            default: ;
        endcase
        disp_min_d = lap_active_q ? lap_min_q : min_q;
        disp_sec_d = lap_active_q ? lap_sec_q : sec_q;
    end

    always_ff @(posedge clk_i) begin
        if (btnr_i) begin
            min_q        <= '0;
            sec_q        <= '0;
            lap_min_q    <= '0;
            lap_sec_q    <= '0;
            disp_min_q   <= '0;
            disp_sec_q   <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            blink_q      <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            min_q        <= min_d;
            sec_q        <= sec_d;
            lap_min_q    <= lap_min_d;
            lap_sec_q    <= lap_sec_d;
            disp_min_q   <= disp_min_d;
            disp_sec_q   <= disp_sec_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            blink_q      <= blink_d;
            done_q       <= done_d;
        end
    end

    assign disp_min_o   = disp_min_q;
    assign disp_sec_o   = disp_sec_q;
    assign running_o    = running_q;
    assign lap_active_o = lap_active_q;
    assign blink_o      = blink_q;
    assign done_o       = done_q;

endmodule
